// File: rtl/dm_pkg.sv
// Shared register map, DMI encodings and dmcontrol layout for the single-hart
// RISC-V debug module (0.13 subset).
package dm_pkg;

    localparam int unsigned DM_DATA0      = 32'h04;
    localparam int unsigned DM_DATA1      = 32'h05;
    localparam int unsigned DM_DMCONTROL  = 32'h10;
    localparam int unsigned DM_DMSTATUS   = 32'h11;
    localparam int unsigned DM_HARTINFO   = 32'h12;
    localparam int unsigned DM_ABSTRACTCS = 32'h16;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        SUCCESS = 2'd0,
        FAILED  = 2'd2
    } dmi_resp_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } dm_state_e;

    typedef struct packed {
        logic        haltreq;
        logic        resumereq;
        logic        hartreset;
        logic        ackhavereset;
        logic [23:0] reserved;
        logic        setresethaltreq;
        logic        clrresethaltreq;
        logic        ndmreset;
        logic        dmactive;
    } dmcontrol_t;

endpackage

// File: rtl/dm_if.sv
// DMI request/response channel: the JTAG DTM is the master, the debug module
// is the slave.
interface dm_if #(
    parameter int DMI_ABITS = 7
);
    logic                 req_valid;
    logic                 req_ready;
    logic [DMI_ABITS-1:0] req_addr;
    logic [1:0]           req_op;
    logic [31:0]          req_data;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_data;
    logic [1:0]           resp_op;

    modport master (
        output req_valid, req_addr, req_op, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_op
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_op
    );
endinterface

// File: rtl/dm_hart_ctrl.sv
// Run-control state for the single hart: halt/resume/reset-halt requests,
// resume acknowledge, havereset tracking and the SoC ndmreset level.
module dm_hart_ctrl
    import dm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ctrl_we,
    input  dmcontrol_t ctrl,
    input  logic       hart_running,
    output logic       dmactive,
    output logic       haltreq,
    output logic       resumereq,
    output logic       resumeack,
    output logic       resethaltreq,
    output logic       ndmreset,
    output logic       havereset
);

    logic ndmreset_fall;
    logic unused_ctrl;

    assign unused_ctrl   = ^{ctrl.hartreset, ctrl.reserved};
    assign ndmreset_fall = ndmreset && ctrl_we && !(ctrl.dmactive && ctrl.ndmreset);

    // A dmcontrol write lands after the resume handshake so a fresh resume
    // request overrides a completion seen on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmactive     <= 1'b0;
            haltreq      <= 1'b0;
            resumereq    <= 1'b0;
            resumeack    <= 1'b0;
            resethaltreq <= 1'b0;
            ndmreset     <= 1'b0;
            havereset    <= 1'b1;
        end else begin
            if (resumereq && hart_running) begin
                resumereq <= 1'b0;
                resumeack <= 1'b1;
            end
            if (ctrl_we) begin
                dmactive <= ctrl.dmactive;
                if (!ctrl.dmactive) begin
                    haltreq      <= 1'b0;
                    resumereq    <= 1'b0;
                    resumeack    <= 1'b0;
                    resethaltreq <= 1'b0;
                    ndmreset     <= 1'b0;
                end else begin
                    haltreq  <= ctrl.haltreq;
                    ndmreset <= ctrl.ndmreset;
                    if (ctrl.resumereq && !ctrl.haltreq) begin
                        resumereq <= 1'b1;
                        resumeack <= 1'b0;
                    end
                    if (ctrl.clrresethaltreq) begin
                        resethaltreq <= 1'b0;
                    end else if (ctrl.setresethaltreq) begin
                        resethaltreq <= 1'b1;
                    end
                end
            end
            if (ndmreset_fall) begin
                havereset <= 1'b1;
            end else if (ctrl_we && ctrl.ackhavereset) begin
                havereset <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/debug_module.sv
// Single-hart RISC-V debug module, DMI responder side.
// Optional DM_ABSTRACT_DATA_EN adds the data0/data1 scratch registers.
module debug_module
    import dm_pkg::*;
#(
    parameter int DMI_ABITS  = 7,
    parameter int DM_VERSION = 2
) (
    input  logic clk,
    input  logic rst_n,
    dm_if.slave  dmi,
    input  logic hart_halted,
    input  logic hart_running,
    output logic haltreq,
    output logic resumereq,
    output logic resethaltreq,
    output logic ndmreset
);

    dm_state_e   state_q, state_d;
    logic        accept;
    dmi_op_e     req_op;
    dmcontrol_t  wr_ctrl;
    logic        dmcontrol_we;
    logic [31:0] rdata;
    logic [31:0] resp_data_d, resp_data_q;
    dmi_resp_e   resp_op_d, resp_op_q;
    logic        dmactive, resumeack, havereset;
    logic [3:0]  datacount;

    assign req_op       = dmi_op_e'(dmi.req_op);
    assign wr_ctrl      = dmcontrol_t'(dmi.req_data);
    assign dmcontrol_we = accept && (req_op == WRITE) && (dmi.req_addr == DMI_ABITS'(DM_DMCONTROL));

`ifdef DM_ABSTRACT_DATA_EN
    logic [31:0] data0_q, data1_q;

    assign datacount = 4'd2;

    // Scratch data is wiped whenever the debugger deactivates the module.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data0_q <= '0;
            data1_q <= '0;
        end else if (dmcontrol_we && !wr_ctrl.dmactive) begin
            data0_q <= '0;
            data1_q <= '0;
        end else if (accept && (req_op == WRITE)) begin
            if (dmi.req_addr == DMI_ABITS'(DM_DATA0)) data0_q <= dmi.req_data;
            if (dmi.req_addr == DMI_ABITS'(DM_DATA1)) data1_q <= dmi.req_data;
        end
    end
`else
    assign datacount = 4'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        dmi.req_ready  = 1'b0;
        dmi.resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                dmi.req_ready = 1'b1;
                if (dmi.req_valid) begin
                    accept  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                dmi.resp_valid = 1'b1;
                if (dmi.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (dmi.req_addr)
`ifdef DM_ABSTRACT_DATA_EN
            DMI_ABITS'(DM_DATA0): rdata = data0_q;
            DMI_ABITS'(DM_DATA1): rdata = data1_q;
`endif
            DMI_ABITS'(DM_DMCONTROL): rdata = {haltreq, 29'b0, ndmreset, dmactive};
            DMI_ABITS'(DM_DMSTATUS): begin
                rdata[19:18] = {2{havereset}};
                rdata[17:16] = {2{resumeack}};
                rdata[11:10] = {2{hart_running}};
                rdata[9:8]   = {2{hart_halted}};
                rdata[7]     = 1'b1;
                rdata[3:0]   = 4'(DM_VERSION);
            end
            DMI_ABITS'(DM_ABSTRACTCS): rdata[3:0] = datacount;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        resp_data_d = '0;
        resp_op_d   = SUCCESS;
        case (req_op)
            READ:    resp_data_d = rdata;
            RSVD:    resp_op_d   = FAILED;
            default: resp_data_d = '0;
        endcase
    end

    // The response is captured on the accepting edge and held until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_data_q <= '0;
            resp_op_q   <= SUCCESS;
        end else if (accept) begin
            resp_data_q <= resp_data_d;
            resp_op_q   <= resp_op_d;
        end
    end

    assign dmi.resp_data = resp_data_q;
    assign dmi.resp_op   = resp_op_q;

    dm_hart_ctrl u_hart_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_we      (dmcontrol_we),
        .ctrl         (wr_ctrl),
        .hart_running (hart_running),
        .dmactive     (dmactive),
        .haltreq      (haltreq),
        .resumereq    (resumereq),
        .resumeack    (resumeack),
        .resethaltreq (resethaltreq),
        .ndmreset     (ndmreset),
        .havereset    (havereset)
    );

endmodule

// File: tb/tb_debug_module.sv
// Scoreboard bench for debug_module: a register-level reference model predicts
// each DMI response and the run-control outputs.
module tb_debug_module;
    import dm_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  op;
    } exp_t;

    logic clk;
    logic rst_n;
    logic hart_halted;
    logic hart_running;
    logic haltreq;
    logic resumereq;
    logic resethaltreq;
    logic ndmreset;

    dm_if #(.DMI_ABITS(7)) dmi ();

    debug_module #(.DMI_ABITS(7), .DM_VERSION(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmi          (dmi),
        .hart_halted  (hart_halted),
        .hart_running (hart_running),
        .haltreq      (haltreq),
        .resumereq    (resumereq),
        .resethaltreq (resethaltreq),
        .ndmreset     (ndmreset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;
    int   rr_mode = 0;
    exp_t sb_q[$];

    logic        model_on = 1'b0;
    logic        m_pending;
    logic        m_dmactive, m_haltreq, m_resumereq, m_resumeack;
    logic        m_resethaltreq, m_ndmreset, m_havereset;
    logic [31:0] m_data0, m_data1;
    logic        m_acc, m_old_nd;
    exp_t        m_e;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] addr);
        logic [31:0] r;
        r = '0;
        case (addr)
`ifdef DM_ABSTRACT_DATA_EN
            7'h04: r = m_data0;
            7'h05: r = m_data1;
            7'h16: r = 32'd2;
`endif
            7'h10: begin
                r[31] = m_haltreq;
                r[1]  = m_ndmreset;
                r[0]  = m_dmactive;
            end
            7'h11: begin
                r[19] = m_havereset;  r[18] = m_havereset;
                r[17] = m_resumeack;  r[16] = m_resumeack;
                r[11] = hart_running; r[10] = hart_running;
                r[9]  = hart_halted;  r[8]  = hart_halted;
                r[7]  = 1'b1;
                r[3:0] = 4'd2;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reference model: requests are taken whenever no response is outstanding;
    // the response reflects state before the accepting edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_on       = 1'b1;
            m_pending      = 1'b0;
            m_dmactive     = 1'b0;
            m_haltreq      = 1'b0;
            m_resumereq    = 1'b0;
            m_resumeack    = 1'b0;
            m_resethaltreq = 1'b0;
            m_ndmreset     = 1'b0;
            m_havereset    = 1'b1;
            m_data0        = '0;
            m_data1        = '0;
            sb_q.delete();
        end else begin
            m_acc = dmi.req_valid && !m_pending;
            if (m_pending && dmi.resp_ready) m_pending = 1'b0;
            if (m_acc) begin
                m_e.data = (dmi.req_op == 2'd1) ? model_read(dmi.req_addr) : 32'd0;
                m_e.op   = (dmi.req_op == 2'd3) ? 2'd2 : 2'd0;
                sb_q.push_back(m_e);
                m_pending = 1'b1;
                acc_cnt++;
            end
            if (m_resumereq && hart_running) begin
                m_resumereq = 1'b0;
                m_resumeack = 1'b1;
            end
            if (m_acc && dmi.req_op == 2'd2) begin
                if (dmi.req_addr == 7'h10) begin
                    m_old_nd   = m_ndmreset;
                    m_dmactive = dmi.req_data[0];
                    if (!dmi.req_data[0]) begin
                        m_haltreq = 0; m_resumereq = 0; m_resumeack = 0;
                        m_resethaltreq = 0; m_ndmreset = 0;
                        m_data0 = '0; m_data1 = '0;
                    end else begin
                        m_haltreq  = dmi.req_data[31];
                        m_ndmreset = dmi.req_data[1];
                        if (dmi.req_data[30] && !dmi.req_data[31]) begin
                            m_resumereq = 1'b1;
                            m_resumeack = 1'b0;
                        end
                        if (dmi.req_data[2]) m_resethaltreq = 1'b0;
                        else if (dmi.req_data[3]) m_resethaltreq = 1'b1;
                    end
                    if (dmi.req_data[28]) m_havereset = 1'b0;
                    if (m_old_nd && !m_ndmreset) m_havereset = 1'b1;
                end
`ifdef DM_ABSTRACT_DATA_EN
                if (dmi.req_addr == 7'h04) m_data0 = dmi.req_data;
                if (dmi.req_addr == 7'h05) m_data1 = dmi.req_data;
`endif
            end
        end
    end

    // Monitor: handshake, run-control outputs and the response at the head of the queue.
    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("req_ready", 32'(dmi.req_ready), 32'(!m_pending));
            checkOutput("resp_valid", 32'(dmi.resp_valid), 32'(m_pending));
            checkOutput("haltreq", 32'(haltreq), 32'(m_haltreq));
            checkOutput("resumereq", 32'(resumereq), 32'(m_resumereq));
            checkOutput("resethaltreq", 32'(resethaltreq), 32'(m_resethaltreq));
            checkOutput("ndmreset", 32'(ndmreset), 32'(m_ndmreset));
            if (dmi.resp_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL resp_unexpected: got data %h with no expected response", dmi.resp_data);
                end else begin
                    checkOutput("resp_data", dmi.resp_data, sb_q[0].data);
                    checkOutput("resp_op", 32'(dmi.resp_op), 32'(sb_q[0].op));
                    if (dmi.resp_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       dmi.resp_ready = 1'b1;
            1:       dmi.resp_ready = 1'b0;
            default: dmi.resp_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        int start;
        int waited;
        dmi.req_valid = 1'b1;
        dmi.req_op    = op;
        dmi.req_addr  = addr;
        dmi.req_data  = data;
        start  = acc_cnt;
        waited = 0;
        while (acc_cnt == start && waited < 64) begin
            tick();
            waited++;
        end
        dmi.req_valid = 1'b0;
        dmi.req_op    = 2'd0;
        if (acc_cnt == start) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: got no acceptance within %0d cycles expected acceptance", waited);
        end
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [6:0]  r_addr;
        logic [31:0] r_data;

        rst_n          = 1'b0;
        hart_halted    = 1'b0;
        hart_running   = 1'b0;
        dmi.req_valid  = 1'b0;
        dmi.req_addr   = '0;
        dmi.req_op     = 2'd0;
        dmi.req_data   = '0;
        dmi.resp_ready = 1'b1;
        ticks(3);
        rst_n = 1'b1;
        $display("[TB] reset released");

        hart_running = 1'b1;
        applyStimulus(READ, 7'h11, 32'h0);
        ticks(2);

        hart_running = 1'b0;
        applyStimulus(WRITE, 7'h10, 32'h8000_0001);
        hart_halted = 1'b1;
        tick();
        applyStimulus(READ, 7'h11, 32'h0);
        applyStimulus(READ, 7'h10, 32'h0);

        hart_halted = 1'b0;
        applyStimulus(WRITE, 7'h10, 32'h4000_0001);
        ticks(5);
        hart_running = 1'b1;
        ticks(2);
        applyStimulus(READ, 7'h11, 32'h0);

        applyStimulus(WRITE, 7'h10, 32'h0000_0003);
        applyStimulus(WRITE, 7'h10, 32'h0000_0001);
        applyStimulus(READ, 7'h11, 32'h0);
        applyStimulus(WRITE, 7'h10, 32'h1000_0001);
        applyStimulus(READ, 7'h11, 32'h0);

        applyStimulus(WRITE, 7'h10, 32'h0000_0009);
        applyStimulus(WRITE, 7'h10, 32'h0000_000D);
        applyStimulus(WRITE, 7'h10, 32'hC000_0001);
        applyStimulus(READ, 7'h12, 32'h0);
        applyStimulus(READ, 7'h7F, 32'h0);
        applyStimulus(NOP, 7'h11, 32'h0);

        rr_mode = 1;
        tick();
        applyStimulus(READ, 7'h11, 32'h0);
        ticks(4);
        rr_mode = 0;
        applyStimulus(RSVD, 7'h10, 32'h8000_0003);
        applyStimulus(READ, 7'h10, 32'h0);

        applyStimulus(WRITE, 7'h04, 32'hDEAD_BEEF);
        applyStimulus(READ, 7'h04, 32'h0);
        applyStimulus(WRITE, 7'h05, 32'h1234_5678);
        applyStimulus(READ, 7'h05, 32'h0);
        applyStimulus(READ, 7'h16, 32'h0);
        applyStimulus(WRITE, 7'h10, 32'h0);
        applyStimulus(READ, 7'h04, 32'h0);

        rr_mode = 1;
        tick();
        applyStimulus(READ, 7'h11, 32'h0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rr_mode = 0;
        ticks(2);

        rr_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) hart_running = ~hart_running;
            if ($urandom_range(0, 3) == 0) hart_halted = ~hart_halted;
            case ($urandom_range(0, 9))
                0:       r_op = NOP;
                1:       r_op = RSVD;
                2, 3, 4: r_op = READ;
                default: r_op = WRITE;
            endcase
            case ($urandom_range(0, 7))
                0:       r_addr = 7'h04;
                1:       r_addr = 7'h05;
                2, 3:    r_addr = 7'h10;
                4:       r_addr = 7'h11;
                5:       r_addr = 7'h12;
                6:       r_addr = 7'h16;
                default: r_addr = 7'($urandom_range(0, 127));
            endcase
            r_data    = $urandom;
            r_data[0] = ($urandom_range(0, 7) != 0);
            applyStimulus(r_op, r_addr, r_data);
            ticks($urandom_range(0, 2));
        end

        rr_mode = 0;
        ticks(6);
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
